// File: rtl/apb_mst_bridge.sv
// APB3 requester: accepts one command at a time on a valid/ready stream, runs a
// SETUP/ACCESS transfer with an optional wait-state timeout, returns the result on a response stream.
module apb_mst_bridge #(
  parameter int ADDR_W  = 8,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 16
) (
  input  logic              PCLK,
  input  logic              PRESETn,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              PSEL,
  output logic              PENABLE,
  output logic              PWRITE,
  output logic [ADDR_W-1:0] PADDR,
  output logic [DATA_W-1:0] PWDATA,
  input  logic [DATA_W-1:0] PRDATA,
  input  logic              PREADY,
  input  logic              PSLVERR,
  output logic [1:0]        dbg_state
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } state_t;

  // A zero-length counter is not legal, so TIMEOUT=0 keeps a single idle bit.
  localparam int CNT_W    = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam int TMO_LAST = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;

  state_t           state, state_d;
  logic [CNT_W-1:0] wait_cnt;
  logic             accept;
  logic             done_ok;
  logic             done_tmo;

  // Both streams: a beat transfers on a rising PCLK edge where valid && ready;
  // valid and its payload hold until that edge, ready never depends on valid.
  assign cmd_ready = (state == IDLE) && (!rsp_valid || rsp_ready);
  assign accept    = cmd_valid && cmd_ready;
  assign PSEL      = (state != IDLE);
  assign PENABLE   = (state == ACCESS);
  assign dbg_state = state;

  always_comb begin
    state_d  = state;
    done_ok  = 1'b0;
    done_tmo = 1'b0;
    case (state)
      IDLE: begin
        if (accept) state_d = SETUP;
      end
      SETUP: begin
        state_d = ACCESS;
      end
      ACCESS: begin
        if (PREADY) begin
          done_ok = 1'b1;
          state_d = IDLE;
        end else if ((TIMEOUT != 0) && (wait_cnt == CNT_W'(TMO_LAST))) begin
          done_tmo = 1'b1;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) state <= IDLE;
    else          state <= state_d;
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      PWRITE    <= 1'b0;
      PADDR     <= '0;
      PWDATA    <= '0;
      wait_cnt  <= '0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      if (accept) begin
        PWRITE <= cmd_write;
        PADDR  <= cmd_addr;
        PWDATA <= cmd_wdata;
      end

      // Cleared outside ACCESS so every transfer starts its wait count at zero.
      if (state != ACCESS)
        wait_cnt <= '0;
      else if ((TIMEOUT != 0) && !PREADY && (wait_cnt != '1))
        wait_cnt <= wait_cnt + 1'b1;

      if (done_ok) begin
        rsp_valid <= 1'b1;
        rsp_rdata <= (PWRITE || PSLVERR) ? '0 : PRDATA;
        rsp_err   <= PSLVERR;
      end else if (done_tmo) begin
        rsp_valid <= 1'b1;
        rsp_rdata <= '0;
        rsp_err   <= 1'b1;
      end else if (rsp_valid && rsp_ready) begin
        rsp_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_apb_mst_bridge.sv
// Bench for apb_mst_bridge: directed APB scenarios plus randomized transfers against
// a reference built from the transfer rules (latency, timeout, response content).
module tb_apb_mst_bridge;

  localparam int AW  = 8;
  localparam int DW  = 32;
  localparam int TMO = 4;

  logic          PCLK;
  logic          PRESETn;
  logic          cmd_valid;
  logic          cmd_ready;
  logic          cmd_write;
  logic [AW-1:0] cmd_addr;
  logic [DW-1:0] cmd_wdata;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [DW-1:0] rsp_rdata;
  logic          rsp_err;
  logic          PSEL;
  logic          PENABLE;
  logic          PWRITE;
  logic [AW-1:0] PADDR;
  logic [DW-1:0] PWDATA;
  logic [DW-1:0] PRDATA;
  logic          PREADY;
  logic          PSLVERR;
  logic [1:0]    dbg_state;

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;

  logic [DW:0] exp_q[$];
  logic [DW:0] last_rsp;

  apb_mst_bridge #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TMO)) dut (
    .PCLK(PCLK), .PRESETn(PRESETn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR), .PWDATA(PWDATA),
    .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR), .dbg_state(dbg_state)
  );

  // clock / reset
  initial PCLK = 1'b0;
  always #5 PCLK = ~PCLK;
  always @(posedge PCLK) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge PCLK);
    #1;
  endtask

  // One full transfer; the slave answers after `waits` ACCESS cycles with PREADY low.
  task automatic run_xfer(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d,
                          input int waits, input logic [DW-1:0] rd, input logic serr);
    logic        timed_out;
    int          exp_lat;
    int          lat;
    logic [DW:0] exp_rsp;
    timed_out = (TMO != 0) && (waits >= TMO);
    exp_lat   = timed_out ? 1 + TMO : 2 + waits;
    if (timed_out)     exp_rsp = {1'b1, {DW{1'b0}}};
    else if (w || serr) exp_rsp = {serr, {DW{1'b0}}};
    else               exp_rsp = {1'b0, rd};
    exp_q.push_back(exp_rsp);

    cmd_valid = 1'b1; cmd_write = w; cmd_addr = a; cmd_wdata = d;
    PREADY = 1'b0;
    #0;
    chk("cmd_ready_before_accept", cmd_ready, 1);
    step();
    cmd_valid = 1'b0; cmd_write = ~w; cmd_addr = ~a; cmd_wdata = ~d;
    lat = 0;
    while (!rsp_valid && lat < 50) begin
      chk("psel_held", PSEL, 1);
      chk("penable_phase", PENABLE, (lat >= 1) ? 1 : 0);
      chk("paddr_stable", PADDR, a);
      chk("pwrite_stable", PWRITE, w);
      chk("pwdata_stable", PWDATA, d);
      if (lat >= 1 && (lat - 1) == waits) begin
        PREADY = 1'b1; PRDATA = rd; PSLVERR = serr;
      end else begin
        PREADY = 1'b0; PRDATA = $urandom; PSLVERR = 1'($urandom_range(0, 1));
      end
      step();
      lat++;
    end
    PREADY = 1'b0; PSLVERR = 1'b0;
    last_rsp = exp_q.pop_front();
    chk("rsp_latency", lat, exp_lat);
    chk("rsp_valid", rsp_valid, 1);
    chk("rsp_rdata", rsp_rdata, last_rsp[DW-1:0]);
    chk("rsp_err", rsp_err, last_rsp[DW]);
    chk("psel_after_done", PSEL, 0);
    chk("penable_after_done", PENABLE, 0);
    chk("paddr_after_done", PADDR, a);
  endtask

  initial begin
    int t0;
    int stall;
    bit pend;
    PRESETn = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0;
    rsp_ready = 1'b1; PRDATA = '0; PREADY = 1'b0; PSLVERR = 1'b0;
    #3;
    chk("rst_cmd_ready", cmd_ready, 1);
    chk("rst_psel", PSEL, 0);
    chk("rst_penable", PENABLE, 0);
    chk("rst_pwrite", PWRITE, 0);
    chk("rst_paddr", PADDR, 0);
    chk("rst_pwdata", PWDATA, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_rdata", rsp_rdata, 0);
    chk("rst_rsp_err", rsp_err, 0);
    step();
    PRESETn = 1'b1;
    step();

    // zero-wait write, 3-wait read, slave error
    run_xfer(1'b1, 8'h10, 32'hDEADBEEF, 0, $urandom, 1'b0);
    run_xfer(1'b0, 8'h10, $urandom, 3, 32'hDEADBEEF, 1'b0);
    run_xfer(1'b0, 8'hFF, $urandom, 0, 32'h1234_5678, 1'b1);
    step();
    chk("drain_rsp_valid", rsp_valid, 0);

    // timeout with response held back, then a late PREADY and a blocked command
    rsp_ready = 1'b0;
    run_xfer(1'b0, 8'h44, $urandom, 1000, $urandom, 1'b0);
    PREADY = 1'b1; PSLVERR = 1'b1; PRDATA = $urandom;
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 8'h20; cmd_wdata = 32'hA5A5_0001;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("bp_cmd_ready", cmd_ready, 0);
      chk("bp_psel", PSEL, 0);
      chk("bp_rsp_valid", rsp_valid, 1);
      chk("bp_rsp_err", rsp_err, 1);
      chk("bp_rsp_rdata", rsp_rdata, 0);
    end
    PREADY = 1'b0; PSLVERR = 1'b0;
    rsp_ready = 1'b1;
    #1;
    chk("bp_release_cmd_ready", cmd_ready, 1);

    // four back-to-back zero-wait transfers
    t0 = cyc;
    run_xfer(1'b1, 8'h20, 32'hA5A5_0001, 0, $urandom, 1'b0);
    run_xfer(1'b0, 8'h21, $urandom, 0, 32'h0BAD_F00D, 1'b0);
    run_xfer(1'b1, 8'h22, 32'hA5A5_0003, 0, $urandom, 1'b0);
    run_xfer(1'b0, 8'h23, $urandom, 0, 32'h7777_1111, 1'b0);
    chk("b2b_cycles", cyc - t0, 12);

    // asynchronous reset in the middle of ACCESS
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 8'h33; cmd_wdata = 32'hCAFE_0033;
    step();
    cmd_valid = 1'b0;
    step();
    chk("pre_rst_psel", PSEL, 1);
    chk("pre_rst_penable", PENABLE, 1);
    #2;
    PRESETn = 1'b0;
    #1;
    chk("mid_rst_psel", PSEL, 0);
    chk("mid_rst_penable", PENABLE, 0);
    chk("mid_rst_rsp_valid", rsp_valid, 0);
    chk("mid_rst_cmd_ready", cmd_ready, 1);
    chk("mid_rst_paddr", PADDR, 0);
    chk("mid_rst_pwdata", PWDATA, 0);
    step();
    PRESETn = 1'b1;
    step();
    chk("post_rst_cmd_ready", cmd_ready, 1);
    chk("post_rst_psel", PSEL, 0);
    chk("post_rst_rsp_valid", rsp_valid, 0);
    chk("post_rst_rsp_err", rsp_err, 0);
    chk("post_rst_rsp_rdata", rsp_rdata, 0);

    // randomized transfers with random response stalls
    pend = 1'b0;
    for (int n = 0; n < 24; n++) begin
      stall = $urandom_range(0, 2);
      rsp_ready = 1'b0;
      for (int s = 0; s < stall; s++) begin
        step();
        chk("rnd_cmd_ready", cmd_ready, pend ? 0 : 1);
        if (pend) begin
          chk("rnd_hold_valid", rsp_valid, 1);
          chk("rnd_hold_rdata", rsp_rdata, last_rsp[DW-1:0]);
          chk("rnd_hold_err", rsp_err, last_rsp[DW]);
        end
      end
      rsp_ready = 1'b1;
      run_xfer(1'($urandom_range(0, 1)), AW'($urandom_range(0, 255)), $urandom,
               $urandom_range(0, 5), $urandom, ($urandom_range(0, 3) == 0));
      pend = 1'b1;
    end
    step();
    chk("final_drain", rsp_valid, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
